serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit unsigned subtractor that computes a − b one bit per clock, LSB first, using a single 1-bit subtract cell (half-subtractor logic extended with a registered borrow) and a borrow flip-flop. It sits directly downstream of the half_subtractor cell: it sequences operand bits into that cell's logic over WIDTH cycles and collects the difference bits into a result register. Control is a start/done handshake, so a small datapath can trade area for latency.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  request; sampled on clk when the block is ready
- a  input  WIDTH  minuend; captured on an accepted start
- b  input  WIDTH  subtrahend; captured on an accepted start
- busy  output  1  high while bit-steps are in progress
- done  output  1  single-cycle pulse; result valid
- diff  output  WIDTH  (a − b) mod 2^WIDTH
- borrow  output  1  final borrow out; 1 iff a < b (unsigned)

## Operation
- FSM states: IDLE, RUN, DONE.
- Ready = state is IDLE or DONE; start is accepted only when ready.
- Accepted start: load a into shift register SA, b into SB, clear borrow register BR, count ← 0, go to RUN.
- RUN, each cycle: with x = SA[0], y = SB[0]:
  - bit d = x ^ y ^ BR
  - BR ← (~x & y) | (~(x ^ y) & BR)
  - shift d into the diff register at the MSB, moving it right one place
  - shift SA and SB right one place
  - count ← count + 1
- After the WIDTH-th bit-step, go to DONE. diff now holds the full result, LSB in bit 0. borrow ← BR.
- DONE lasts one cycle; done = 1. Then go to IDLE unless a start is accepted in that cycle, in which case go to RUN (back-to-back).
- start in RUN is ignored: no reload, no effect on the count.
- diff and borrow are valid from the DONE cycle until the next accepted start. While RUN is in progress, diff shows partial shift contents and is not valid.
- The counter is ceil(log2(WIDTH+1)) bits wide. With WIDTH = 1, RUN lasts one cycle.
- a and b are don't-care except on an accepted start.

## Timing
- Reset (rst sampled high on clk): state IDLE, busy 0, done 0, diff 0, borrow 0, BR 0, count 0, SA/SB 0.
- Reset overrides start and any in-progress operation. A reset in RUN aborts with no done pulse.
- Start accepted at edge E0: busy = 1 after E0 through E_WIDTH−1.
- Bit-steps occur at edges E1..E_WIDTH.
- After E_WIDTH: busy = 0, done = 1, diff/borrow final. Latency from the start edge to done is WIDTH cycles.
- After E_WIDTH+1: done = 0, state IDLE (or RUN if start was high during DONE).
- Throughput for back-to-back operation: one result every WIDTH+1 cycles.
- done is never high for two consecutive cycles. busy and done are never high together.

## Test plan
- WIDTH=8, a=13, b=5, start pulsed one cycle -> done exactly 8 cycles after the start edge, diff=0x08, borrow=0, busy high for 8 cycles.
- WIDTH=8, a=5, b=13 -> diff=0xF8, borrow=1; a=0x00, b=0x01 -> diff=0xFF, borrow=1; a=b=0xA5 -> diff=0x00, borrow=0.
- WIDTH=1, all four (a,b) pairs -> (diff,borrow) = (0,0), (1,1), (1,0), (0,0) for (0,0), (0,1), (1,0), (1,1); done 1 cycle after start.
- WIDTH=8: start a=200, b=100, then pulse start with a=1, b=2 mid-RUN -> second start ignored; diff=100, borrow=0.
- WIDTH=8: hold start high continuously with a=9, b=3, changing operands to a=3, b=9 in the DONE cycle -> first result 6/0, second 0xFA/1; done pulses 9 cycles apart.
- WIDTH=8: start, assert rst at the 4th RUN cycle -> no done pulse; next cycle all outputs 0, state IDLE; a fresh start then completes correctly.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, start/done handshake
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, borrow_q, borrow_d;
    logic             accept, x, y;
    assign accept = start && (state_q != RUN);
    assign x      = sa_q[0];
    assign y      = sb_q[0];
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    // next state: load on accepted start, one subtract step per RUN cycle
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        if (accept) begin
            sa_d    = a;
            sb_d    = b;
            br_d    = 1'b0;
            cnt_d   = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            br_d              = (~x & y) | (~(x ^ y) & br_q);
            diff_d            = diff_q >> 1;
            diff_d[WIDTH-1]   = x ^ y ^ br_q;
            sa_d              = sa_q >> 1;
            sb_d              = sb_q >> 1;
            cnt_d             = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d  = DONE;
                borrow_d = br_d;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for WIDTH=8 and WIDTH=1 instances
module tb_serial_subtractor;
    logic       clk = 1'b0, rst = 1'b1;
    logic       start8 = 1'b0, start1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic [0:0] a1 = '0, b1 = '0, diff1;
    logic       busy8, done8, borrow8, busy1, done1, borrow1;
    logic [8:0] q8[$];
    logic [1:0] q1[$];
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );
    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
    );

    task automatic go8(input logic [7:0] a, input logic [7:0] b);
        a8 = a; b8 = b; start8 = 1'b1;
        q8.push_back({a < b, 8'(a - b)});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic go1(input logic a, input logic b);
        a1 = a; b1 = b; start1 = 1'b1;
        q1.push_back({~a & b, a ^ b});
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait8(output int n, output int nb, output int both);
        n = 0; nb = 0; both = 0;
        forever begin
            if (busy8 && done8) both++;
            if (done8 || n >= 40) break;
            if (busy8) nb++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait1(output int n);
        n = 0;
        while (!done1 && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy8, done8, diff8, borrow8} !== 11'b0) begin
            bad++;
            $display("FAIL reset8 got=%h exp=000", {busy8, done8, diff8, borrow8});
        end
        total++;
        if ({busy1, done1, diff1, borrow1} !== 4'b0) begin
            bad++;
            $display("FAIL reset1 got=%h exp=0", {busy1, done1, diff1, borrow1});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [15:0] ops [4] = '{16'h0D05, 16'h050D, 16'h0001, 16'hA5A5};
        logic [8:0]  e;
        int n, nb, both;
        for (int i = 0; i < 4; i++) begin
            go8(ops[i][15:8], ops[i][7:0]);
            wait8(n, nb, both);
            e = q8.pop_front();
            total++;
            if (n != 8) begin bad++; $display("FAIL basic_latency[%0d] got=%0d exp=8", i, n); end
            total++;
            if (nb != 8 || both != 0) begin bad++; $display("FAIL basic_busy[%0d] got=%0d/%0d exp=8/0", i, nb, both); end
            total++;
            if ({borrow8, diff8} !== e) begin bad++; $display("FAIL basic_result[%0d] got=%h exp=%h", i, {borrow8, diff8}, e); end
            @(negedge clk);
            total++;
            if (done8 !== 1'b0) begin bad++; $display("FAIL basic_pulse[%0d] got=%b exp=0", i, done8); end
        end
    endtask

    task automatic test_width1;
        logic [1:0] e;
        int n;
        for (int i = 0; i < 4; i++) begin
            go1(i[1], i[0]);
            wait1(n);
            e = q1.pop_front();
            total++;
            if (n != 1) begin bad++; $display("FAIL w1_latency[%0d] got=%0d exp=1", i, n); end
            total++;
            if ({borrow1, diff1} !== e) begin bad++; $display("FAIL w1_result[%0d] got=%b exp=%b", i, {borrow1, diff1}, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start;
        logic [8:0] e;
        int n, nb, both, extra;
        go8(8'd200, 8'd100);
        repeat (2) @(negedge clk);
        a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait8(n, nb, both);
        e = q8.pop_front();
        total++;
        if (n != 5) begin bad++; $display("FAIL ignore_latency got=%0d exp=5", n); end
        total++;
        if ({borrow8, diff8} !== e) begin bad++; $display("FAIL ignore_result got=%h exp=%h", {borrow8, diff8}, e); end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        total++;
        if (extra != 0) begin bad++; $display("FAIL ignore_no_rerun got=%0d exp=0", extra); end
    endtask

    task automatic test_back_to_back;
        logic [8:0] e;
        int n, nb, both;
        a8 = 8'd9; b8 = 8'd3; start8 = 1'b1;
        q8.push_back({1'b0, 8'd6});
        @(negedge clk);
        wait8(n, nb, both);
        e = q8.pop_front();
        total++;
        if ({borrow8, diff8} !== e) begin bad++; $display("FAIL b2b_first got=%h exp=%h", {borrow8, diff8}, e); end
        a8 = 8'd3; b8 = 8'd9;
        q8.push_back({1'b1, 8'hFA});
        @(negedge clk);
        start8 = 1'b0;
        total++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin bad++; $display("FAIL b2b_restart got=%b%b exp=10", busy8, done8); end
        wait8(n, nb, both);
        e = q8.pop_front();
        total++;
        if (n + 1 != 9) begin bad++; $display("FAIL b2b_spacing got=%0d exp=9", n + 1); end
        total++;
        if ({borrow8, diff8} !== e) begin bad++; $display("FAIL b2b_second got=%h exp=%h", {borrow8, diff8}, e); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        logic [8:0] e;
        int n, nb, both, extra;
        go8(8'd50, 8'd20);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q8.delete();
        total++;
        if ({busy8, done8, diff8, borrow8} !== 11'b0) begin
            bad++;
            $display("FAIL abort_clear got=%h exp=000", {busy8, done8, diff8, borrow8});
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        total++;
        if (extra != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", extra); end
        go8(8'd77, 8'd100);
        wait8(n, nb, both);
        e = q8.pop_front();
        total++;
        if (n != 8 || {borrow8, diff8} !== e) begin
            bad++;
            $display("FAIL abort_fresh got=%0d/%h exp=8/%h", n, {borrow8, diff8}, e);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_width1;
        test_ignore_start;
        test_back_to_back;
        test_reset_abort;
        total++;
        if (q8.size() + q1.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", q8.size() + q1.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
